ccl_rom_loader: RTL and testbench



---
 rtl/ccl_pkg.sv | 31 +++
 rtl/ccl_rom_loader_if.sv | 11 +
 rtl/ccl_req_slot.sv | 46 ++++
 rtl/ccl_rom_loader.sv | 152 +++++++++++++++
 tb/tb_ccl_rom_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccl_pkg.sv
// Shared types and default memory map for the Crazy Climber ROM loader.
package ccl_pkg;

  typedef enum logic [1:0] {
    REG_PRG  = 2'd0,
    REG_GFX  = 2'd1,
    REG_SND  = 2'd2,
    REG_PROM = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } state_e;

  localparam logic [15:0] PRG_END_DEF  = 16'h6000;
  localparam logic [15:0] GFX_END_DEF  = 16'h9000;
  localparam logic [15:0] SND_END_DEF  = 16'hB000;
  localparam logic [15:0] PROM_END_DEF = 16'hB060;
  localparam int          RST_HOLD_DEF = 1024;

  typedef struct packed {
    region_e     region;
    logic [15:0] offset;
    logic [7:0]  data;
  } slot_entry_t;

endpackage

// File: rtl/ccl_rom_loader_if.sv
// ROM write port from the loader into the game memories.
interface ccl_rom_loader_if;
  logic        mem_req;
  logic [1:0]  mem_region;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (output mem_req, mem_region, mem_addr, mem_data, input mem_ack);
  modport slave  (input mem_req, mem_region, mem_addr, mem_data, output mem_ack);
endinterface

// File: rtl/ccl_req_slot.sv
// One-entry request/acknowledge buffer; refilling in the ack cycle keeps 1 byte/cycle.
module ccl_req_slot
  import ccl_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load,
  input  slot_entry_t load_entry,
  input  logic        ack,
  output logic        full,
  output logic        stall,
  output logic        empty_next,
  output slot_entry_t entry
);

  logic        full_q, full_d;
  slot_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (full_q && ack) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d  = 1'b1;
      entry_d = load_entry;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full       = full_q;
  assign stall      = full_q & ~ack;
  assign empty_next = ~full_d;
  assign entry      = entry_q;

endmodule

// File: rtl/ccl_rom_loader.sv
// Decodes the hps_io download into the four game memory regions and owns the game reset.
module ccl_rom_loader
  import ccl_pkg::*;
#(
  parameter logic [15:0] PRG_END  = PRG_END_DEF,
  parameter logic [15:0] GFX_END  = GFX_END_DEF,
  parameter logic [15:0] SND_END  = SND_END_DEF,
  parameter logic [15:0] PROM_END = PROM_END_DEF,
  parameter int          RST_HOLD = RST_HOLD_DEF
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  ccl_rom_loader_if.master        mem,
  output logic                    game_reset,
  output logic                    dl_done,
  output logic                    dl_error,
  output logic [15:0]             byte_count
);

  localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic              dl_prev_q;
  logic [15:0]       byte_count_q, byte_count_d;
  logic              error_q, error_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic        dl_rise, wr_live, addr_ok, capture, drop, drained;
  logic        slot_full, slot_stall, slot_empty_next;
  logic [15:0] addr_lo;
  slot_entry_t new_entry, slot_entry;

  assign addr_lo = ioctl_addr[15:0];
  assign dl_rise = ioctl_download & ~dl_prev_q;
  assign wr_live = ioctl_wr & ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign addr_ok = (ioctl_addr[24:16] == 9'd0) && (addr_lo < PROM_END);
  assign capture = wr_live & addr_ok & ~slot_stall;
  assign drop    = wr_live & ~(addr_ok & ~slot_stall);

  always_comb begin
    new_entry.data   = ioctl_dout;
    new_entry.region = REG_PROM;
    new_entry.offset = addr_lo - SND_END;
    if (addr_lo < PRG_END) begin
      new_entry.region = REG_PRG;
      new_entry.offset = addr_lo;
    end else if (addr_lo < GFX_END) begin
      new_entry.region = REG_GFX;
      new_entry.offset = addr_lo - PRG_END;
    end else if (addr_lo < SND_END) begin
      new_entry.region = REG_SND;
      new_entry.offset = addr_lo - GFX_END;
    end
  end

  ccl_req_slot u_slot (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load       (capture),
    .load_entry (new_entry),
    .ack        (mem.mem_ack),
    .full       (slot_full),
    .stall      (slot_stall),
    .empty_next (slot_empty_next),
    .entry      (slot_entry)
  );

  // Going straight from LOAD to HOLD when the slot is already empty starts the
  // reset hold on the very edge the last write leaves the buffer.
  assign drained = slot_empty_next &&
                   ((state_q == ST_DRAIN) || ((state_q == ST_LOAD) && !ioctl_download));

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    error_d      = error_q;
    hold_cnt_d   = hold_cnt_q;

    if (capture && (byte_count_q != 16'hFFFF)) begin
      byte_count_d = byte_count_q + 16'd1;
    end
    if (drop) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_IDLE, ST_DRAIN, ST_RUN: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (drained) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      if (byte_count_q != PROM_END) begin
        error_d = 1'b1;
      end
    end

    // A new download restarts from any state; a pending slot entry still drains.
    if (dl_rise) begin
      state_d      = ST_LOAD;
      byte_count_d = '0;
      error_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      dl_prev_q    <= 1'b0;
      byte_count_q <= '0;
      error_q      <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= ioctl_download;
      byte_count_q <= byte_count_d;
      error_q      <= error_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign ioctl_wait     = slot_stall;
  assign mem.mem_req    = slot_full;
  assign mem.mem_region = slot_entry.region;
  assign mem.mem_addr   = slot_entry.offset;
  assign mem.mem_data   = slot_entry.data;
  assign game_reset     = (state_q != ST_RUN) | dl_rise;
  assign dl_done        = (state_q == ST_RUN) & ~error_q;
  assign dl_error       = error_q;
  assign byte_count     = byte_count_q;

endmodule

// File: tb/tb_ccl_rom_loader.sv
// Bench for ccl_rom_loader: a transaction-level model of the download is compared every cycle.
module tb_ccl_rom_loader;
  import ccl_pkg::*;

  localparam int RST_HOLD   = 1024;
  localparam int IMAGE_SIZE = 'hB060;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ack_drv = 1'b1;
  logic        ioctl_wait, game_reset, dl_done, dl_error;
  logic [15:0] byte_count;

  ccl_rom_loader_if mem_bus ();
  assign mem_bus.mem_ack = ack_drv;

  ccl_rom_loader #(.RST_HOLD(RST_HOLD)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem            (mem_bus),
    .game_reset     (game_reset),
    .dl_done        (dl_done),
    .dl_error       (dl_error),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 draining, 3 holding reset, 4 running.
  typedef struct {
    int region;
    int offset;
    int data;
  } wr_t;

  wr_t pend[$];
  int  phase, m_count, m_hold;
  bit  m_err, m_prev_dl;

  function automatic wr_t decode(input int a, input int d);
    int  bounds[4] = '{32'h6000, 32'h9000, 32'hB000, 32'hB060};
    int  base = 0;
    bit  found = 0;
    wr_t w;
    w.region = 0;
    w.offset = 0;
    w.data   = d;
    for (int r = 0; r < 4; r++) begin
      if (!found && a < bounds[r]) begin
        w.region = r;
        w.offset = a - base;
        found    = 1;
      end
      base = bounds[r];
    end
    return w;
  endfunction

  task automatic model_reset();
    pend.delete();
    phase     = 0;
    m_count   = 0;
    m_hold    = 0;
    m_err     = 0;
    m_prev_dl = 0;
  endtask

  task automatic enter_hold();
    phase  = 3;
    m_hold = RST_HOLD;
    if (m_count != IMAGE_SIZE) m_err = 1;
  endtask

  task automatic model_step();
    bit req, ack, rise;
    int a;
    req  = (pend.size() > 0);
    ack  = ack_drv;
    rise = ioctl_download && !m_prev_dl;
    if (req && ack) void'(pend.pop_front());
    if (ioctl_wr && (phase == 1 || phase == 2)) begin
      a = int'(ioctl_addr);
      if (a >= IMAGE_SIZE) m_err = 1;
      else if (req && !ack) m_err = 1;
      else begin
        pend.push_back(decode(a, int'(ioctl_dout)));
        if (m_count < 'hFFFF) m_count++;
      end
    end
    case (phase)
      1: if (!ioctl_download) begin
           if (pend.size() == 0) enter_hold();
           else phase = 2;
         end
      2: if (pend.size() == 0) enter_hold();
      3: begin
           m_hold--;
           if (m_hold == 0) phase = 4;
         end
      default: ;
    endcase
    if (rise) begin
      phase   = 1;
      m_count = 0;
      m_err   = 0;
    end
    m_prev_dl = ioctl_download;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Trackers used by the full-image checks.
  bit          track_en = 0;
  bit          wait_seen = 0;
  bit          prev_req = 0;
  bit          prev_gr = 1;
  int          t_empty = -1;
  int          t_fall = -1;
  logic [1:0]  last_region = '0;
  logic [15:0] last_addr = '0;

  task automatic compare_cycle();
    bit exp_req, exp_gr;
    exp_req = (pend.size() > 0);
    exp_gr  = (phase != 4) || (ioctl_download && !m_prev_dl);
    checkOutput("mem_req", mem_bus.mem_req, exp_req);
    checkOutput("ioctl_wait", ioctl_wait, exp_req && !ack_drv);
    checkOutput("game_reset", game_reset, exp_gr);
    checkOutput("dl_done", dl_done, (phase == 4) && !m_err);
    checkOutput("dl_error", dl_error, m_err);
    checkOutput("byte_count", byte_count, m_count);
    if (exp_req && mem_bus.mem_req === 1'b1) begin
      checkOutput("mem_region", mem_bus.mem_region, pend[0].region);
      checkOutput("mem_addr", mem_bus.mem_addr, pend[0].offset);
      checkOutput("mem_data", mem_bus.mem_data, pend[0].data);
    end
    if (track_en) begin
      if (ioctl_wait === 1'b1) wait_seen = 1;
      if (mem_bus.mem_req === 1'b1) begin
        last_region = mem_bus.mem_region;
        last_addr   = mem_bus.mem_addr;
      end
      if (prev_req && mem_bus.mem_req === 1'b0) t_empty = cyc;
      if (prev_gr && game_reset === 1'b0) t_fall = cyc;
    end
    prev_req = (mem_bus.mem_req === 1'b1);
    prev_gr  = (game_reset === 1'b1);
  endtask

  initial forever begin
    @(negedge clk_sys);
    if (reset_n) compare_cycle();
  end

  task automatic applyStimulus(input bit dl, input bit wr, input int addr, input int data, input bit ack);
    @(posedge clk_sys);
    #1;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = 25'(addr);
    ioctl_dout     = 8'(data);
    ack_drv        = ack;
  endtask

  task automatic waitRun(input string tag);
    for (int i = 0; i < RST_HOLD + 200; i++) begin
      @(negedge clk_sys);
      if (game_reset === 1'b0) break;
    end
    #1;
    checkOutput({tag, "_reached_run"}, game_reset, 0);
  endtask

  int bnd_addr[6] = '{'h5FFF, 'h6000, 'h8FFF, 'h9000, 'hB000, 'hB05F};
  int bnd_reg[6]  = '{0, 1, 1, 2, 3, 3};
  int bnd_off[6]  = '{'h5FFF, 0, 'h2FFF, 0, 0, 'h5F};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, a;
    $display("[TB] start");
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    checkOutput("rst_game_reset", game_reset, 1);
    checkOutput("rst_mem_req", mem_bus.mem_req, 0);
    checkOutput("rst_byte_count", byte_count, 0);
    checkOutput("rst_dl_done", dl_done, 0);
    checkOutput("rst_dl_error", dl_error, 0);

    // Out-of-range address, then boundary decode in the same download.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 1, 'hB060, 'h11, 1);
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("oor_no_req", mem_bus.mem_req, 0);
    checkOutput("oor_error", dl_error, 1);
    checkOutput("oor_not_counted", byte_count, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, bnd_addr[i], 'h40 + i, 1);
      applyStimulus(1, 0, 0, 0, 1);
      @(negedge clk_sys);
      checkOutput("bnd_req", mem_bus.mem_req, 1);
      checkOutput("bnd_region", mem_bus.mem_region, bnd_reg[i]);
      checkOutput("bnd_offset", mem_bus.mem_addr, bnd_off[i]);
    end
    applyStimulus(0, 0, 0, 0, 1);
    waitRun("bnd");
    checkOutput("bnd_done", dl_done, 0);
    checkOutput("bnd_count", byte_count, 6);

    // Re-download from RUN, back-pressure and dropped byte.
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("redl_game_reset_same_cycle", game_reset, 1);
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("redl_count_clear", byte_count, 0);
    checkOutput("redl_error_clear", dl_error, 0);
    checkOutput("redl_done_clear", dl_done, 0);
    applyStimulus(1, 1, 'h10, 'hA5, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk_sys);
      checkOutput("bp_wait", ioctl_wait, 1);
      checkOutput("bp_data_stable", mem_bus.mem_data, 'hA5);
    end
    applyStimulus(1, 1, 'h11, 'h5A, 1);
    @(negedge clk_sys);
    checkOutput("bp_ack_wait", ioctl_wait, 0);
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("bp_nogap_req", mem_bus.mem_req, 1);
    checkOutput("bp_nogap_addr", mem_bus.mem_addr, 'h11);
    checkOutput("bp_nogap_data", mem_bus.mem_data, 'h5A);
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("bp_released", mem_bus.mem_req, 0);
    applyStimulus(1, 1, 'h20, 'h11, 0);
    applyStimulus(1, 1, 'h21, 'h22, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("drop_error", dl_error, 1);
    checkOutput("drop_count", byte_count, 3);
    checkOutput("drop_kept_data", mem_bus.mem_data, 'h11);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    waitRun("bp");

    // Short image.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 'h100; i++) applyStimulus(1, 1, i, i, 1);
    applyStimulus(0, 0, 0, 0, 1);
    waitRun("short");
    checkOutput("short_error", dl_error, 1);
    checkOutput("short_done", dl_done, 0);
    checkOutput("short_count", byte_count, 'h100);

    // Full image, ack tied high.
    applyStimulus(1, 0, 0, 0, 1);
    t_empty  = -1;
    t_fall   = -1;
    wait_seen = 0;
    track_en = 1;
    for (int i = 0; i < IMAGE_SIZE; i++) applyStimulus(1, 1, i, (i & 'hFF) ^ 'h3C, 1);
    applyStimulus(0, 0, 0, 0, 1);
    waitRun("full");
    track_en = 0;
    checkOutput("full_wait_never", wait_seen, 0);
    checkOutput("full_last_region", last_region, 3);
    checkOutput("full_last_offset", last_addr, 'h5F);
    checkOutput("full_count", byte_count, 'hB060);
    checkOutput("full_done", dl_done, 1);
    checkOutput("full_error", dl_error, 0);
    checkOutput("full_hold_cycles", t_fall - t_empty, RST_HOLD);

    // Randomized download with random acks, stray addresses and a random drain.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 330; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) a = 'hB060 + $urandom_range(0, 'h4F9F);
      else if (r == 1) a = $urandom_range(0, 'hFF) | (1 << (16 + $urandom_range(0, 8)));
      else a = $urandom_range(0, IMAGE_SIZE - 1);
      applyStimulus(i < 300, ($urandom_range(0, 3) != 0), a, $urandom_range(0, 255),
                    ($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 0, 0, 0, 1);
    waitRun("rand");

    // Asynchronous reset with a pending request.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 1, 'h1234, 'h77, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk_sys);
    checkOutput("ar_pending", mem_bus.mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("ar_req_dropped", mem_bus.mem_req, 0);
    checkOutput("ar_game_reset", game_reset, 1);
    checkOutput("ar_count", byte_count, 0);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (5) applyStimulus(0, 0, 0, 0, 1);
    @(negedge clk_sys);
    checkOutput("ar_idle_game_reset", game_reset, 1);
    checkOutput("ar_idle_req", mem_bus.mem_req, 0);
    checkOutput("ar_idle_done", dl_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
